// File: rtl/boot_pkg.sv
// boot_pkg: shared state type and default constants for the boot vector injector.
package boot_pkg;
  typedef enum logic [1:0] {ARMED, OPC, ADDR, DONE} boot_state_t;
  localparam logic [7:0] DEF_OPCODE = 8'hC3;
  localparam logic [63:0] DEF_VEC_TABLE = {16'hFD00, 16'hFF00, 16'h0000, 16'hF800};
endpackage

// File: rtl/rd_edge_det.sv
// rd_edge_det: rising-edge detector for a level CPU read strobe.
module rd_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic rd,
  output logic rd_edge
);
  logic rd_q;
  always_ff @(posedge clk) rd_q <= reset ? 1'b0 : rd;
  assign rd_edge = rd & ~rd_q;
endmodule

// File: rtl/boot_vector_inject.sv
// boot_vector_inject: injects a jump opcode and target address onto the CPU bus after reset.
// Define BOOT_VEC_OVERRIDE_EN to add a runtime-writable target override register.
module boot_vector_inject
  import boot_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NUM_VEC = 4,
  parameter logic [7:0] OPCODE = DEF_OPCODE,
  parameter logic [NUM_VEC*ADDR_W-1:0] VEC_TABLE = DEF_VEC_TABLE,
  localparam int SEL_W = NUM_VEC > 1 ? $clog2(NUM_VEC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd,
  input  logic [SEL_W-1:0] vec_sel,
  input  logic             rearm,
  output logic [7:0]       data_out,
  output logic             valid,
  output logic             done
`ifdef BOOT_VEC_OVERRIDE_EN
  ,
  input  logic             ovr_we,
  input  logic [ADDR_W-1:0] ovr_addr
`endif
);
  localparam int NB = ADDR_W / 8;
  localparam int IDX_W = NB > 1 ? $clog2(NB) : 1;
  boot_state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0] data_n;
  logic done_n, rd_edge;
  logic [SEL_W-1:0] sel;
  logic [ADDR_W-1:0] target, table_entry, next_target;
  rd_edge_det u_rd_edge (.clk(clk), .reset(reset), .rd(rd), .rd_edge(rd_edge));
  assign sel = int'(vec_sel) >= NUM_VEC ? '0 : vec_sel;
  assign table_entry = VEC_TABLE[sel*ADDR_W +: ADDR_W];
`ifdef BOOT_VEC_OVERRIDE_EN
  logic ovr_set;
  logic [ADDR_W-1:0] ovr_val;
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_set <= 1'b0;
      ovr_val <= '0;
    end else if (ovr_we) begin
      ovr_set <= 1'b1;
      ovr_val <= ovr_addr;
    end
  end
  assign next_target = ovr_set ? ovr_val : table_entry;
`else
  assign next_target = table_entry;
`endif
  // idx points at the byte most recently emitted while in ADDR
  always_comb begin
    state_n = state;
    idx_n = idx;
    data_n = data_out;
    done_n = 1'b0;
    if (rearm) begin
      state_n = ARMED;
      idx_n = '0;
    end else if (rd_edge)
      case (state)
        ARMED: begin
          state_n = OPC;
          idx_n = '0;
          data_n = OPCODE;
        end
        OPC: begin
          state_n = ADDR;
          data_n = target[{idx, 3'b000} +: 8];
        end
        ADDR: begin
          if (idx == IDX_W'(NB - 1)) begin
            state_n = DONE;
            done_n = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
            data_n = target[{idx_n, 3'b000} +: 8];
          end
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARMED;
      idx <= '0;
      data_out <= 8'h00;
      done <= 1'b0;
      target <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      data_out <= data_n;
      done <= done_n;
      if (state == ARMED) target <= next_target;
    end
  end
  assign valid = state != DONE;
endmodule

// File: tb/tb_boot_vector_inject.sv
// tb_boot_vector_inject: directed and randomized checks against a byte-stream reference model.
module tb_boot_vector_inject;
  localparam int NB = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd = 1'b0;
  logic rearm = 1'b0;
  logic [1:0] vec_sel = '0;
  logic [7:0] data_out;
  logic valid, done;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] tbl [4];
  int m_pos = 0;
  logic [15:0] m_tgt = '0;
  logic [7:0] m_data = '0;
  logic m_done = 1'b0;
  logic m_rdq = 1'b0;
  logic m_ovr_set = 1'b0;
  logic [15:0] m_ovr = '0;
`ifdef BOOT_VEC_OVERRIDE_EN
  logic ovr_we = 1'b0;
  logic [15:0] ovr_addr = '0;
`endif
  boot_vector_inject dut (
    .clk(clk), .reset(reset), .rd(rd), .vec_sel(vec_sel), .rearm(rearm),
    .data_out(data_out), .valid(valid), .done(done)
`ifdef BOOT_VEC_OVERRIDE_EN
    , .ovr_we(ovr_we), .ovr_addr(ovr_addr)
`endif
  );
  always #5 clk = ~clk;
  // model: m_pos counts read edges since arming; opcode, then target bytes LSB first, then done
  task automatic tick();
    logic e;
    e = rd && !m_rdq;
    if (reset) begin
      m_pos = 0; m_data = '0; m_done = 1'b0; m_rdq = 1'b0; m_ovr_set = 1'b0;
    end else begin
      m_rdq = rd;
      m_done = 1'b0;
      if (rearm) m_pos = 0;
      else if (e && m_pos < NB + 2) begin
        if (m_pos == 0) begin
          m_tgt = m_ovr_set ? m_ovr : tbl[vec_sel];
          m_data = 8'hC3;
        end else if (m_pos <= NB) m_data = m_tgt[(m_pos-1)*8 +: 8];
        else m_done = 1'b1;
        m_pos++;
      end
`ifdef BOOT_VEC_OVERRIDE_EN
      if (ovr_we) begin
        m_ovr_set = 1'b1;
        m_ovr = ovr_addr;
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    rd = 1'b1; tick();
    rd = 1'b0; tick();
  endtask
  task automatic do_rearm();
    rearm = 1'b1; tick();
    rearm = 1'b0; tick();
  endtask
  task automatic test_reset();
    reset = 1'b1; rd = 1'b1; rearm = 1'b1;
    tick(); tick();
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_out); end
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL reset_valid: got %b expected 1", valid); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    rd = 1'b0; rearm = 1'b0; tick();
    reset = 1'b0; tick();
  endtask
  task automatic test_sequence();
    logic [7:0] exp [3] = '{8'hC3, 8'h00, 8'hFD};
    int dcnt = 0;
    do_rearm();
    vec_sel = 2'd3;
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; tick();
      dcnt += int'(done);
      n_tests++; if (valid !== (i < 3)) begin n_fail++; $display("FAIL seq_valid%0d: got %b expected %b", i, valid, i < 3); end
      rd = 1'b0; tick();
      dcnt += int'(done);
      if (i < 3) begin
        n_tests++; if (data_out !== exp[i]) begin n_fail++; $display("FAIL seq_byte%0d: got %h expected %h", i, data_out, exp[i]); end
      end
    end
    n_tests++; if (dcnt !== 1) begin n_fail++; $display("FAIL seq_done_count: got %0d expected 1", dcnt); end
    pulse();
    n_tests++; if (data_out !== 8'hFD) begin n_fail++; $display("FAIL seq_hold_data: got %h expected fd", data_out); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL seq_hold_valid: got %b expected 0", valid); end
  endtask
  task automatic test_sel_change();
    do_rearm();
    vec_sel = 2'd2;
    pulse();
    vec_sel = 2'd3;
    pulse();
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL sel_byte1: got %h expected 00", data_out); end
    pulse();
    n_tests++; if (data_out !== 8'hFF) begin n_fail++; $display("FAIL sel_byte2: got %h expected ff", data_out); end
  endtask
  task automatic test_rd_held();
    do_rearm();
    vec_sel = 2'd3;
    rd = 1'b1;
    repeat (10) tick();
    rd = 1'b0; tick();
    n_tests++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL held_byte: got %h expected c3", data_out); end
    pulse();
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL held_next: got %h expected 00", data_out); end
  endtask
  task automatic test_rearm_mid();
    logic [7:0] exp [3] = '{8'hC3, 8'h00, 8'hFD};
    int dcnt = 0;
    do_rearm();
    vec_sel = 2'd3;
    pulse(); pulse();
    rearm = 1'b1; tick(); dcnt += int'(done);
    rearm = 1'b0; tick(); dcnt += int'(done);
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rearm_valid: got %b expected 1", valid); end
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; tick();
      if (i < 3) dcnt += int'(done);
      rd = 1'b0; tick();
      if (i < 3) begin
        n_tests++; if (data_out !== exp[i] || valid !== 1'b1) begin n_fail++; $display("FAIL rearm_byte%0d: got %h/%b expected %h/1", i, data_out, valid, exp[i]); end
      end
    end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rearm_end_valid: got %b expected 0", valid); end
    n_tests++; if (dcnt !== 0) begin n_fail++; $display("FAIL rearm_no_done: got %0d expected 0", dcnt); end
  endtask
  task automatic test_rearm_priority();
    do_rearm();
    vec_sel = 2'd3;
    pulse(); pulse();
    rd = 1'b1; rearm = 1'b1; tick();
    n_tests++; if (data_out !== 8'h00 || valid !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL prio_state: got %h/%b/%b expected 00/1/0", data_out, valid, done); end
    rd = 1'b0; rearm = 1'b0; tick();
    pulse();
    n_tests++; if (data_out !== 8'hC3) begin n_fail++; $display("FAIL prio_armed: got %h expected c3", data_out); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(0, 1));
      rearm = ($urandom_range(0, 19) == 0);
      vec_sel = 2'($urandom);
`ifdef BOOT_VEC_OVERRIDE_EN
      ovr_we = ($urandom_range(0, 39) == 0);
      ovr_addr = 16'($urandom);
`endif
      tick();
      n_tests++;
      if (data_out !== m_data || valid !== (m_pos < NB + 2) || done !== m_done) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %h/%b/%b expected %h/%b/%b", i, data_out, valid, done, m_data, m_pos < NB + 2, m_done);
      end
    end
    rd = 1'b0; rearm = 1'b0;
`ifdef BOOT_VEC_OVERRIDE_EN
    ovr_we = 1'b0;
`endif
    tick();
  endtask
`ifdef BOOT_VEC_OVERRIDE_EN
  task automatic test_override();
    logic [7:0] exp [3] = '{8'hC3, 8'h34, 8'h12};
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    vec_sel = 2'd3;
    ovr_we = 1'b1; ovr_addr = 16'h1234; tick();
    ovr_we = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      pulse();
      if (i < 3) begin
        n_tests++; if (data_out !== exp[i]) begin n_fail++; $display("FAIL ovr_byte%0d: got %h expected %h", i, data_out, exp[i]); end
      end
    end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ovr_valid: got %b expected 0", valid); end
  endtask
`endif
  initial begin
    tbl = '{16'hF800, 16'h0000, 16'hFF00, 16'hFD00};
    test_reset();
    test_sequence();
    test_sel_change();
    test_rd_held();
    test_rearm_mid();
    test_rearm_priority();
    test_random();
`ifdef BOOT_VEC_OVERRIDE_EN
    test_override();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
